// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Accumulates NTERMS unsigned 4-bit products from the 2-bit
//               multiplier into one ACC_W-bit frame sum with a sticky
//               overflow flag. Input and output use valid/ready handshakes.
//               Optional macro ACC_SATURATE_EN: clamp the accumulator at
//               2^ACC_W-1 instead of wrapping when a frame overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int ACC_W  = 8,   // accumulator / result width, 4..16
  parameter int NTERMS = 4    // products per frame, 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic [7:0]       cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] C_NTERMS = 8'(NTERMS);

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] C_ACC_MAX = '1;
`endif

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             w_accept;
  logic             w_release;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_add;
  logic [7:0]       w_cnt_inc;

  // Handshake qualifiers and the one-bit-wider addition of the next product
  assign w_accept  = in_valid & in_ready_q;
  assign w_release = out_valid_q & out_ready;
  assign w_sum_ext = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, prod};
  assign w_carry   = w_sum_ext[ACC_W];
  assign w_cnt_inc = cnt_q + 8'd1;

`ifdef ACC_SATURATE_EN
  // Once clamped, any further add carries again, so the clamp persists
  assign w_acc_add = w_carry ? C_ACC_MAX : w_sum_ext[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W; the carry is only recorded in ovf
  assign w_acc_add = w_sum_ext[ACC_W-1:0];
`endif

  // Next-state logic: clear beats any transfer, accepts only outside DONE
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACC: begin
          if (w_accept) begin
            acc_d   = w_acc_add;
            ovf_d   = ovf_q | w_carry;
            cnt_d   = w_cnt_inc;
            state_d = (w_cnt_inc == C_NTERMS) ? ST_DONE : ST_ACC;
          end
        end
        ST_DONE: begin
          if (w_release) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers; in_ready/out_valid are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != ST_DONE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = acc_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;

endmodule
`default_nettype wire
